param_seq_alu: RTL and testbench

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

---
 rtl/param_seq_alu.sv | 150 +++++++++++++++
 tb/tb_param_seq_alu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_alu.sv
// Parameterised sequential ALU with valid/ready handshakes.
// Single-cycle ops finish in one cycle; MUL/DIVU/REMU iterate one bit per cycle.
module param_seq_alu #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] r0_data,
  input  logic [DATA_W-1:0] r1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              B_PCSrc,
  output logic              o_carry,
  output logic              o_zero
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] LAST = SH_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [3:0]        op_q;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] a_q, b_q;
  logic [SH_W-1:0]   cnt;

  logic              long_op;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] res;
  logic              carry, take;

  logic [DATA_W:0]   acc_mul, rem_sh, rem_nx;
  logic              ge;
  logic [DATA_W-1:0] quo_nx, iter_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign long_op   = (alu_op == 4'hA) || (alu_op == 4'hB) || (alu_op == 4'hC);
  assign shamt     = r1_data[SH_W-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    take  = 1'b0;
    case (alu_op)
      4'h0: {carry, res} = {1'b0, r0_data} + {1'b0, r1_data};
      4'h1: begin
        res   = r0_data - r1_data;
        carry = (r0_data >= r1_data);
      end
      4'h2: res = r0_data & r1_data;
      4'h3: res = r0_data | r1_data;
      4'h4: res = r0_data ^ r1_data;
      4'h5: res = r0_data << shamt;
      4'h6: res = r0_data >> shamt;
      4'h7: res = $unsigned($signed(r0_data) >>> shamt);
      4'h8: res = {{(DATA_W-1){1'b0}}, ($signed(r0_data) < $signed(r1_data))};
      4'h9: res = {{(DATA_W-1){1'b0}}, (r0_data < r1_data)};
      4'hD: take = (r0_data == r1_data);
      4'hE: take = (r0_data != r1_data);
      4'hF: take = ($signed(r0_data) < $signed(r1_data));
      default: ;
    endcase
  end

  // One step of shift-add multiply (acc/a_q/b_q = product/multiplier/multiplicand)
  // or restoring divide (acc/a_q/b_q = remainder/quotient-dividend/divisor).
  // A zero divisor always subtracts, naturally yielding all-ones and the dividend.
  always_comb begin
    acc_mul  = a_q[0] ? (acc + {1'b0, b_q}) : acc;
    rem_sh   = {acc[DATA_W-1:0], a_q[DATA_W-1]};
    ge       = (rem_sh >= {1'b0, b_q});
    rem_nx   = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
    quo_nx   = {a_q[DATA_W-2:0], ge};
    iter_res = acc_mul[DATA_W-1:0];
    if (op_q == 4'hB)      iter_res = quo_nx;
    else if (op_q == 4'hC) iter_res = rem_nx[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = long_op ? CALC : DONE;
      CALC: if (cnt == LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      o_data  <= '0;
      B_PCSrc <= 1'b0;
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= alu_op;
          a_q  <= r0_data;
          b_q  <= r1_data;
          acc  <= '0;
          cnt  <= '0;
          if (!long_op) begin
            o_data  <= res;
            o_carry <= carry;
            B_PCSrc <= take;
            o_zero  <= (res == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q == 4'hA) begin
            acc <= acc_mul;
            a_q <= a_q >> 1;
            b_q <= b_q << 1;
          end else begin
            acc <= rem_nx;
            a_q <= quo_nx;
          end
          if (cnt == LAST) begin
            cnt     <= '0;
            o_data  <= iter_res;
            o_carry <= 1'b0;
            B_PCSrc <= 1'b0;
            o_zero  <= (iter_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Bench for param_seq_alu: 8-bit and 16-bit instances driven in lockstep and
// compared against an arithmetic reference model.
module tb_param_seq_alu;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  alu_op = '0;
  logic [15:0] ra = '0, rb = '0;

  logic        rdy8, v8, pc8, c8, z8;
  logic [7:0]  d8;
  logic        rdy16, v16, pc16, c16, z16;
  logic [15:0] d16;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  param_seq_alu #(.DATA_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .alu_op(alu_op),
    .r0_data(ra[7:0]), .r1_data(rb[7:0]), .out_valid(v8), .out_ready(out_ready),
    .o_data(d8), .B_PCSrc(pc8), .o_carry(c8), .o_zero(z8)
  );

  param_seq_alu #(.DATA_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .alu_op(alu_op),
    .r0_data(ra), .r1_data(rb), .out_valid(v16), .out_ready(out_ready),
    .o_data(d16), .B_PCSrc(pc16), .o_carry(c16), .o_zero(z16)
  );

  function automatic void model(input logic [3:0] op, input int unsigned w,
                                input longint unsigned a_in, input longint unsigned b_in,
                                output longint unsigned d, output logic c, output logic pc);
    longint unsigned mask, a, b;
    longint sa, sb;
    int unsigned sh;
    mask = (64'd1 << w) - 1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a;
    sb = b;
    if (a >= (64'd1 << (w - 1))) sa = sa - longint'(64'd1 << w);
    if (b >= (64'd1 << (w - 1))) sb = sb - longint'(64'd1 << w);
    sh = int'(b % w);
    d = 0; c = 1'b0; pc = 1'b0;
    case (op)
      4'h0: begin d = (a + b) & mask; c = ((a + b) > mask); end
      4'h1: begin d = (a - b) & mask; c = (a >= b); end
      4'h2: d = a & b;
      4'h3: d = a | b;
      4'h4: d = a ^ b;
      4'h5: d = (a << sh) & mask;
      4'h6: d = a >> sh;
      4'h7: begin d = sa >>> sh; d = d & mask; end
      4'h8: d = (sa < sb) ? 1 : 0;
      4'h9: d = (a < b) ? 1 : 0;
      4'hA: d = (a * b) & mask;
      4'hB: d = (b == 0) ? mask : a / b;
      4'hC: d = (b == 0) ? a : a % b;
      4'hD: pc = (a == b);
      4'hE: pc = (a != b);
      default: pc = (sa < sb);
    endcase
  endfunction

  // Issues one request to both instances (assumed idle, out_ready=1), collects
  // both results, checks them against the model and returns the 8-bit result.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [7:0] rd, output logic rpc, output logic rc, output logic rz);
    logic got8, got16, cp8, cc8, cz8, cp16, cc16, cz16, ep, ec;
    logic [7:0]  cd8;
    logic [15:0] cd16;
    longint unsigned ed;
    int cyc, lat8, lat16, el;
    alu_op = op; ra = a; rb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 4'($urandom); ra = 16'($urandom); rb = 16'($urandom);
    cyc = 1; got8 = 1'b0; got16 = 1'b0; lat8 = 0; lat16 = 0;
    cd8 = '0; cp8 = 0; cc8 = 0; cz8 = 0; cd16 = '0; cp16 = 0; cc16 = 0; cz16 = 0;
    while (!(got8 && got16) && cyc <= 40) begin
      if (!got8) begin
        tests++;
        if (rdy8 !== 1'b0) begin
          fails++; $display("FAIL busy_ready8 cyc=%0d got %b exp 0", cyc, rdy8);
        end
        if (v8) begin got8 = 1'b1; lat8 = cyc; cd8 = d8; cp8 = pc8; cc8 = c8; cz8 = z8; end
      end
      if (!got16) begin
        if (v16) begin got16 = 1'b1; lat16 = cyc; cd16 = d16; cp16 = pc16; cc16 = c16; cz16 = z16; end
      end
      if (!(got8 && got16)) begin
        in_valid = (!rdy8 && !rdy16) ? 1'($urandom) : 1'b0;
        alu_op = 4'($urandom); ra = 16'($urandom); rb = 16'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (!(got8 && got16)) begin
      fails++; $display("FAIL timeout op=%h got8=%b got16=%b exp both 1", op, got8, got16);
    end
    el = (op == 4'hA || op == 4'hB || op == 4'hC) ? 9 : 1;
    tests++;
    if (lat8 !== el) begin
      fails++; $display("FAIL latency8 op=%h got %0d exp %0d", op, lat8, el);
    end
    el = (op == 4'hA || op == 4'hB || op == 4'hC) ? 17 : 1;
    tests++;
    if (lat16 !== el) begin
      fails++; $display("FAIL latency16 op=%h got %0d exp %0d", op, lat16, el);
    end
    model(op, 8, longint'(a), longint'(b), ed, ec, ep);
    tests++;
    if ({cd8, cp8, cc8, cz8} !== {ed[7:0], ep, ec, (ed[7:0] == 8'h0)}) begin
      fails++;
      $display("FAIL result8 op=%h a=%h b=%h got d=%h pc=%b c=%b z=%b exp d=%h pc=%b c=%b z=%b",
               op, a[7:0], b[7:0], cd8, cp8, cc8, cz8, ed[7:0], ep, ec, (ed[7:0] == 8'h0));
    end
    model(op, 16, longint'(a), longint'(b), ed, ec, ep);
    tests++;
    if ({cd16, cp16, cc16, cz16} !== {ed[15:0], ep, ec, (ed[15:0] == 16'h0)}) begin
      fails++;
      $display("FAIL result16 op=%h a=%h b=%h got d=%h pc=%b c=%b z=%b exp d=%h pc=%b c=%b z=%b",
               op, a, b, cd16, cp16, cc16, cz16, ed[15:0], ep, ec, (ed[15:0] == 16'h0));
    end
    @(posedge clk); #1;
    tests++;
    if ({rdy8, rdy16, v8, v16} !== 4'b1100) begin
      fails++; $display("FAIL back_to_idle got rdy=%b%b v=%b%b exp rdy=11 v=00", rdy8, rdy16, v8, v16);
    end
    rd = cd8; rpc = cp8; rc = cc8; rz = cz8;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({rdy8, v8, d8, pc8, c8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      fails++; $display("FAIL reset8 got rdy=%b v=%b d=%h pc=%b c=%b z=%b exp 1 0 00 0 0 0",
                        rdy8, v8, d8, pc8, c8, z8);
    end
    tests++;
    if ({rdy16, v16, d16, pc16, c16, z16} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      fails++; $display("FAIL reset16 got rdy=%b v=%b d=%h exp 1 0 0000", rdy16, v16, d16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [7:0] d; logic p, c, z;
    run_op(4'h0, 16'h00FF, 16'h0001, d, p, c, z);
    tests++;
    if ({d, c, z, p} !== {8'h00, 3'b110}) begin
      fails++; $display("FAIL add_ff_01 got d=%h c=%b z=%b pc=%b exp d=00 c=1 z=1 pc=0", d, c, z, p);
    end
  endtask

  task automatic test_mul();
    logic [7:0] d; logic p, c, z;
    run_op(4'hA, 16'h0012, 16'h000D, d, p, c, z);
    tests++;
    if (d !== 8'hEA) begin
      fails++; $display("FAIL mul_12_0d got %h exp EA", d);
    end
  endtask

  task automatic test_div();
    logic [7:0] d; logic p, c, z;
    logic [7:0] exp_d [4] = '{8'h0E, 8'h02, 8'hFF, 8'h37};
    logic [3:0] ops [4] = '{4'hB, 4'hC, 4'hB, 4'hC};
    logic [15:0] as [4] = '{16'h64, 16'h64, 16'h37, 16'h37};
    logic [15:0] bs [4] = '{16'h07, 16'h07, 16'h00, 16'h00};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], d, p, c, z);
      tests++;
      if (d !== exp_d[i]) begin
        fails++; $display("FAIL divrem_%0d got %h exp %h", i, d, exp_d[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [7:0] d; logic p, c, z;
    run_op(4'hF, 16'h0080, 16'h0001, d, p, c, z);
    tests++;
    if ({p, d, z} !== {1'b1, 8'h00, 1'b1}) begin
      fails++; $display("FAIL blt_80_01 got pc=%b d=%h z=%b exp pc=1 d=00 z=1", p, d, z);
    end
    run_op(4'hD, 16'h005A, 16'h005A, d, p, c, z);
    tests++;
    if (p !== 1'b1) begin fails++; $display("FAIL beq_5a got pc=%b exp 1", p); end
    run_op(4'hE, 16'h005A, 16'h005A, d, p, c, z);
    tests++;
    if (p !== 1'b0) begin fails++; $display("FAIL bne_5a got pc=%b exp 0", p); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic p, c, z;
    out_ready = 1'b0;
    alu_op = 4'h1; ra = 16'h0010; rb = 16'h0020; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      alu_op = 4'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      tests++;
      if ({v8, rdy8, d8, c8, pc8} !== {1'b1, 1'b0, 8'hF0, 2'b00}) begin
        fails++; $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b d=%h c=%b pc=%b exp 1 0 F0 0 0",
                          i, v8, rdy8, d8, c8, pc8);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if ({v8, d8} !== {1'b1, 8'hF0}) begin
      fails++; $display("FAIL stall_last got v=%b d=%h exp 1 F0", v8, d8);
    end
    @(posedge clk); #1;
    tests++;
    if ({rdy8, v8, rdy16, v16} !== 4'b1010) begin
      fails++; $display("FAIL stall_release got rdy8=%b v8=%b rdy16=%b v16=%b exp 1 0 1 0",
                        rdy8, v8, rdy16, v16);
    end
    run_op(4'h4, 16'h00A5, 16'h000F, d, p, c, z);
  endtask

  task automatic test_reset_midcalc();
    logic [7:0] d; logic p, c, z;
    alu_op = 4'hB; ra = 16'h0064; rb = 16'h0007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({v8, rdy8, d8, v16, rdy16} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b1}) begin
      fails++; $display("FAIL async_reset got v8=%b rdy8=%b d8=%h v16=%b rdy16=%b exp 0 1 00 0 1",
                        v8, rdy8, d8, v16, rdy16);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'h7, 16'h0080, 16'h0003, d, p, c, z);
    tests++;
    if (d !== 8'hF0) begin fails++; $display("FAIL sra_after_reset got %h exp F0", d); end
  endtask

  task automatic test_random();
    logic [7:0] d; logic p, c, z;
    logic [15:0] a, b;
    for (int i = 0; i < 5000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 15) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) b = a;
      run_op(4'($urandom), a, b, d, p, c, z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_branch();
    test_backpressure();
    test_reset_midcalc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
